arm_instr_loader: RTL and testbench

Encoder and loader that is the inverse of the instruction decoder in the multicycle ARM controller. It accepts decoded instruction fields over a valid/ready handshake and buffers them in a small FIFO. It encodes each entry into a 32-bit ARM machine word and writes the words sequentially into the unified instruction/data memory. The CPU is held in reset (cpu_hold) until the final word has been written.

---
 rtl/arm_instr_loader.sv | 213 +++++++++++++++++++++
 tb/tb_arm_instr_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_instr_loader.sv
// Buffers decoded ARM instruction fields, encodes them to machine words and
// writes them sequentially into memory while holding the CPU in reset.
module arm_instr_loader #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_class,
    input  logic [1:0]  in_mul,
    input  logic [3:0]  in_cond,
    input  logic [3:0]  in_cmd,
    input  logic        in_s,
    input  logic [3:0]  in_rn,
    input  logic [3:0]  in_rd,
    input  logic [3:0]  in_rm,
    input  logic [3:0]  in_rs,
    input  logic [23:0] in_imm,
    input  logic        in_last,
    input  logic        restart,
    input  logic        mem_busy,
    output logic        mem_we,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wd,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    typedef struct packed {
        logic [1:0]  cls;
        logic [1:0]  mul;
        logic [3:0]  cond;
        logic [3:0]  cmd;
        logic        s;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [3:0]  rm;
        logic [3:0]  rs;
        logic [23:0] imm;
        logic        last;
    } entry_t;

    // Inverse of the controller's decoder.
    function automatic logic [31:0] encode(input entry_t e);
        logic [31:0] w;
        w = '0;
        case (e.cls)
            2'b00: begin
                case (e.mul)
                    2'b00:   w = {e.cond, 3'b000, e.cmd, e.s, e.rn, e.rd, 8'h00, e.rm};
                    2'b01:   w = {e.cond, 6'b000000, 1'b0, e.s, e.rd, 4'b0000, e.rs, 4'b1001, e.rm};
                    default: w = {e.cond, 5'b00001, e.mul[0], 1'b0, e.s, e.rd, e.rn, e.rs, 4'b1001, e.rm};
                endcase
            end
            2'b01:   w = {e.cond, 3'b001, e.cmd, e.s, e.rn, e.rd, e.imm[11:0]};
            2'b10:   w = {e.cond, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, e.s, e.rn, e.rd, e.imm[11:0]};
            default: w = {e.cond, 4'b1010, e.imm};
        endcase
        return w;
    endfunction

    state_t          state_q, state_d;
    entry_t          fifo_q [DEPTH];
    entry_t          fifo_d [DEPTH];
    logic [PW:0]     wr_q, wr_d, rd_q, rd_d;
    logic [31:0]     count_q, count_d;
    logic            mem_we_q, mem_we_d;
    logic [31:0]     mem_adr_q, mem_adr_d;
    logic [31:0]     mem_wd_q, mem_wd_d;
    logic            wlast_q, wlast_d;
    logic            ovf_q, ovf_d;
    logic            cpu_hold_q, cpu_hold_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            in_ready_q, in_ready_d;

    entry_t          in_entry, head;
    logic [PW:0]     occ, occ_next;
    logic            empty, accept, ovf_hit, store, wr_done, can_issue, issue;

    assign in_entry  = '{cls: in_class, mul: in_mul, cond: in_cond, cmd: in_cmd, s: in_s,
                         rn: in_rn, rd: in_rd, rm: in_rm, rs: in_rs, imm: in_imm, last: in_last};
    assign occ       = wr_q - rd_q;
    assign empty     = (wr_q == rd_q);
    // Empty FIFO bypass lets an accepted bundle be written on the very next cycle.
    assign head      = empty ? in_entry : fifo_q[rd_q[PW-1:0]];
    assign accept    = in_valid & in_ready_q;
    assign ovf_hit   = (count_q + 32'(occ)) == 32'(MAX_WORDS);
    assign store     = accept & ~ovf_hit;
    assign wr_done   = mem_we_q & ~mem_busy;
    assign can_issue = (state_q != S_DONE) & (~mem_we_q | ~mem_busy) & ~wlast_q;
    assign issue     = can_issue & (~empty | store);
    assign occ_next  = wr_d - rd_d;

    always_comb begin
        state_d    = state_q;
        fifo_d     = fifo_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        count_d    = count_q;
        mem_we_d   = mem_we_q;
        mem_adr_d  = mem_adr_q;
        mem_wd_d   = mem_wd_q;
        wlast_d    = wlast_q;
        ovf_d      = ovf_q;
        cpu_hold_d = cpu_hold_q;
        done_d     = done_q;
        err_d      = err_q;
        in_ready_d = in_ready_q;

        if (state_q == S_DONE) begin
            if (restart) begin
                state_d    = S_IDLE;
                count_d    = '0;
                wr_d       = '0;
                rd_d       = '0;
                cpu_hold_d = 1'b1;
                done_d     = 1'b0;
                err_d      = 1'b0;
                in_ready_d = 1'b1;
            end
        end else begin
            if (state_q == S_IDLE && accept) state_d = S_LOAD;
            if (accept && ovf_hit) ovf_d = 1'b1;

            if (issue) begin
                mem_we_d  = 1'b1;
                mem_wd_d  = encode(head);
                mem_adr_d = BASE_ADDR + (count_q << 2);
                count_d   = count_q + 32'd1;
                wlast_d   = head.last;
                if (!empty) rd_d = rd_q + (PW+1)'(1);
            end else if (wr_done) begin
                mem_we_d = 1'b0;
            end

            if (store && !(issue && empty)) begin
                fifo_d[wr_q[PW-1:0]] = in_entry;
                wr_d = wr_q + (PW+1)'(1);
            end

            // Finish on the last word's completion or once an overflow has drained.
            if ((wr_done && wlast_q) || (ovf_q && empty && (!mem_we_q || !mem_busy))) begin
                state_d    = S_DONE;
                mem_we_d   = 1'b0;
                wr_d       = '0;
                rd_d       = '0;
                wlast_d    = 1'b0;
                err_d      = ovf_d;
                ovf_d      = 1'b0;
                cpu_hold_d = 1'b0;
                done_d     = 1'b1;
                in_ready_d = 1'b0;
            end else begin
                in_ready_d = (occ_next != (PW+1)'(DEPTH));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            mem_we_q   <= 1'b0;
            mem_adr_q  <= BASE_ADDR;
            mem_wd_q   <= '0;
            wlast_q    <= 1'b0;
            ovf_q      <= 1'b0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            mem_we_q   <= mem_we_d;
            mem_adr_q  <= mem_adr_d;
            mem_wd_q   <= mem_wd_d;
            wlast_q    <= wlast_d;
            ovf_q      <= ovf_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
            in_ready_q <= in_ready_d;
        end
    end

    // FIFO storage needs no reset; pointers define validity.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign in_ready = in_ready_q;
    assign mem_we   = mem_we_q;
    assign mem_adr  = mem_adr_q;
    assign mem_wd   = mem_wd_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_arm_instr_loader.sv
// Directed bench for arm_instr_loader: default instance plus a MAX_WORDS=2 instance.
module tb_arm_instr_loader;

    logic        clk = 1'b0;
    logic        reset_a, reset_b;
    logic        in_valid, in_s, in_last, restart, mem_busy;
    logic [1:0]  in_class, in_mul;
    logic [3:0]  in_cond, in_cmd, in_rn, in_rd, in_rm, in_rs;
    logic [23:0] in_imm;
    logic        in_ready_a, mem_we_a, cpu_hold_a, done_a, err_a;
    logic        in_ready_b, mem_we_b, cpu_hold_b, done_b, err_b;
    logic [31:0] mem_adr_a, mem_wd_a, mem_adr_b, mem_wd_b;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] cap_adr_a[$], cap_wd_a[$], cap_adr_b[$], cap_wd_b[$];
    logic [31:0] exp_wd[$];

    always #5 clk = ~clk;

    arm_instr_loader u_dut_a (
        .clk(clk), .reset(reset_a), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_class(in_class), .in_mul(in_mul), .in_cond(in_cond), .in_cmd(in_cmd), .in_s(in_s),
        .in_rn(in_rn), .in_rd(in_rd), .in_rm(in_rm), .in_rs(in_rs), .in_imm(in_imm),
        .in_last(in_last), .restart(restart), .mem_busy(mem_busy), .mem_we(mem_we_a),
        .mem_adr(mem_adr_a), .mem_wd(mem_wd_a), .cpu_hold(cpu_hold_a), .done(done_a), .err(err_a)
    );

    arm_instr_loader #(.MAX_WORDS(2)) u_dut_b (
        .clk(clk), .reset(reset_b), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_class(in_class), .in_mul(in_mul), .in_cond(in_cond), .in_cmd(in_cmd), .in_s(in_s),
        .in_rn(in_rn), .in_rd(in_rd), .in_rm(in_rm), .in_rs(in_rs), .in_imm(in_imm),
        .in_last(in_last), .restart(restart), .mem_busy(mem_busy), .mem_we(mem_we_b),
        .mem_adr(mem_adr_b), .mem_wd(mem_wd_b), .cpu_hold(cpu_hold_b), .done(done_b), .err(err_b)
    );

    // Record every completed write.
    always @(posedge clk) begin
        if (reset_a && mem_we_a && !mem_busy) begin
            cap_adr_a.push_back(mem_adr_a);
            cap_wd_a.push_back(mem_wd_a);
        end
        if (reset_b && mem_we_b && !mem_busy) begin
            cap_adr_b.push_back(mem_adr_b);
            cap_wd_b.push_back(mem_wd_b);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit sel_b, input logic [1:0] cls, input logic [1:0] mul,
                        input logic [3:0] cond, input logic [3:0] cmd, input logic s,
                        input logic [3:0] rn, input logic [3:0] rd, input logic [3:0] rm,
                        input logic [3:0] rs, input logic [23:0] imm, input logic last);
        bit ok;
        bit rdy;
        ok = 1'b0;
        in_class = cls; in_mul = mul; in_cond = cond; in_cmd = cmd; in_s = s;
        in_rn = rn; in_rd = rd; in_rm = rm; in_rs = rs; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            rdy = sel_b ? in_ready_b : in_ready_a;
            tick();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) check("push_timeout", 32'd0, 32'd1);
    endtask

    // ADD R1,R2,#k
    task automatic push_add(input bit sel_b, input logic [23:0] k, input logic last);
        push(sel_b, 2'b01, 2'b00, 4'hE, 4'b0100, 1'b0, 4'd2, 4'd1, 4'd0, 4'd0, k, last);
    endtask

    task automatic wait_done(input bit sel_b, input string tag);
        for (int i = 0; i < 100; i++) begin
            if (sel_b ? done_b : done_a) break;
            tick();
        end
        check(tag, 32'(sel_b ? done_b : done_a), 32'd1);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic clear_caps();
        cap_adr_a.delete(); cap_wd_a.delete();
        cap_adr_b.delete(); cap_wd_b.delete();
    endtask

    task automatic check_caps(input bit sel_b, input string tag);
        int n;
        logic [31:0] got_wd, got_adr;
        n = sel_b ? cap_wd_b.size() : cap_wd_a.size();
        check({tag, "_count"}, 32'(n), 32'(exp_wd.size()));
        for (int i = 0; i < exp_wd.size(); i++) begin
            got_wd  = 32'hDEADBEEF;
            got_adr = 32'hDEADBEEF;
            if (i < n) begin
                got_wd  = sel_b ? cap_wd_b[i]  : cap_wd_a[i];
                got_adr = sel_b ? cap_adr_b[i] : cap_adr_a[i];
            end
            check($sformatf("%s_wd%0d", tag, i), got_wd, exp_wd[i]);
            check($sformatf("%s_adr%0d", tag, i), got_adr, 32'(4 * i));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_a = 1'b0; reset_b = 1'b0; in_valid = 1'b0; restart = 1'b0; mem_busy = 1'b0;
        in_class = '0; in_mul = '0; in_cond = '0; in_cmd = '0; in_s = 1'b0;
        in_rn = '0; in_rd = '0; in_rm = '0; in_rs = '0; in_imm = '0; in_last = 1'b0;
        tick(); tick(); tick();

        check("rst_mem_we", 32'(mem_we_a), 32'd0);
        check("rst_mem_adr", mem_adr_a, 32'h0);
        check("rst_mem_wd", mem_wd_a, 32'h0);
        check("rst_cpu_hold", 32'(cpu_hold_a), 32'd1);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_in_ready", 32'(in_ready_a), 32'd1);
        reset_a = 1'b1;
        tick();

        // Single ADD R1,R2,#5 marked last
        clear_caps();
        push_add(1'b0, 24'd5, 1'b1);
        check("add_we", 32'(mem_we_a), 32'd1);
        check("add_adr", mem_adr_a, 32'h0);
        check("add_wd", mem_wd_a, 32'hE2821005);
        check("add_done_early", 32'(done_a), 32'd0);
        tick();
        check("add_done", 32'(done_a), 32'd1);
        check("add_cpu_hold", 32'(cpu_hold_a), 32'd0);
        check("add_we_drop", 32'(mem_we_a), 32'd0);
        check("add_ready_done", 32'(in_ready_a), 32'd0);
        exp_wd = '{32'hE2821005};
        check_caps(1'b0, "add");
        do_restart();
        check("rs1_cpu_hold", 32'(cpu_hold_a), 32'd1);
        check("rs1_done", 32'(done_a), 32'd0);
        check("rs1_in_ready", 32'(in_ready_a), 32'd1);

        // SUBS R3,R4,R5 / STR R1,[R0,#8] / B +2
        clear_caps();
        push(1'b0, 2'b00, 2'b00, 4'hE, 4'b0010, 1'b1, 4'd4, 4'd3, 4'd5, 4'd0, 24'd0, 1'b0);
        push(1'b0, 2'b10, 2'b00, 4'hE, 4'b0000, 1'b0, 4'd0, 4'd1, 4'd0, 4'd0, 24'd8, 1'b0);
        push(1'b0, 2'b11, 2'b00, 4'hE, 4'b0000, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 24'd2, 1'b1);
        wait_done(1'b0, "seq_done");
        exp_wd = '{32'hE0543005, 32'hE5801008, 32'hEA000002};
        check_caps(1'b0, "seq");
        do_restart();

        // UMULL / SMULL R6,R7,R8,R9 then MUL R2,R3,R4
        clear_caps();
        push(1'b0, 2'b00, 2'b10, 4'hE, 4'b0000, 1'b0, 4'd7, 4'd6, 4'd9, 4'd8, 24'd0, 1'b0);
        push(1'b0, 2'b00, 2'b11, 4'hE, 4'b0000, 1'b0, 4'd7, 4'd6, 4'd9, 4'd8, 24'd0, 1'b0);
        push(1'b0, 2'b00, 2'b01, 4'hE, 4'b0000, 1'b0, 4'd0, 4'd2, 4'd3, 4'd4, 24'd0, 1'b1);
        wait_done(1'b0, "mul_done");
        exp_wd = '{32'hE0867899, 32'hE0C67899, 32'hE0020493};
        check_caps(1'b0, "mul");
        do_restart();

        // Memory stall on the second write while the FIFO fills
        clear_caps();
        push_add(1'b0, 24'd1, 1'b0);
        push_add(1'b0, 24'd2, 1'b0);
        check("busy_adr0", mem_adr_a, 32'h4);
        check("busy_wd0", mem_wd_a, 32'hE2821002);
        mem_busy = 1'b1;
        for (int k = 3; k <= 6; k++) push_add(1'b0, 24'(k), 1'b0);
        in_class = 2'b01; in_imm = 24'd7; in_last = 1'b1; in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("busy_ready%0d", c), 32'(in_ready_a), 32'd0);
            check($sformatf("busy_we%0d", c), 32'(mem_we_a), 32'd1);
            check($sformatf("busy_adr%0d", c), mem_adr_a, 32'h4);
            check($sformatf("busy_wd%0d", c), mem_wd_a, 32'hE2821002);
            tick();
        end
        mem_busy = 1'b0;
        push_add(1'b0, 24'd7, 1'b1);
        wait_done(1'b0, "busy_done");
        exp_wd = '{32'hE2821001, 32'hE2821002, 32'hE2821003, 32'hE2821004,
                   32'hE2821005, 32'hE2821006, 32'hE2821007};
        check_caps(1'b0, "busy");
        do_restart();

        // Overflow on the MAX_WORDS=2 instance
        reset_a = 1'b0;
        reset_b = 1'b1;
        tick();
        clear_caps();
        push_add(1'b1, 24'd1, 1'b0);
        push_add(1'b1, 24'd2, 1'b0);
        push_add(1'b1, 24'd3, 1'b0);
        wait_done(1'b1, "ovf_done");
        check("ovf_err", 32'(err_b), 32'd1);
        check("ovf_cpu_hold", 32'(cpu_hold_b), 32'd0);
        exp_wd = '{32'hE2821001, 32'hE2821002};
        check_caps(1'b1, "ovf");
        do_restart();
        check("ovf_rs_cpu_hold", 32'(cpu_hold_b), 32'd1);
        check("ovf_rs_err", 32'(err_b), 32'd0);
        check("ovf_rs_done", 32'(done_b), 32'd0);
        reset_b = 1'b0;
        reset_a = 1'b1;
        tick();

        // Reset in the middle of a load with two queued entries
        clear_caps();
        push_add(1'b0, 24'd1, 1'b0);
        mem_busy = 1'b1;
        push_add(1'b0, 24'd2, 1'b0);
        push_add(1'b0, 24'd3, 1'b0);
        check("mid_we_held", 32'(mem_we_a), 32'd1);
        reset_a = 1'b0;
        tick();
        check("mid_we", 32'(mem_we_a), 32'd0);
        check("mid_cpu_hold", 32'(cpu_hold_a), 32'd1);
        check("mid_in_ready", 32'(in_ready_a), 32'd1);
        check("mid_adr", mem_adr_a, 32'h0);
        reset_a = 1'b1;
        mem_busy = 1'b0;
        tick();
        clear_caps();
        push(1'b0, 2'b11, 2'b00, 4'hE, 4'b0000, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 24'd2, 1'b1);
        wait_done(1'b0, "mid_done");
        exp_wd = '{32'hEA000002};
        check_caps(1'b0, "mid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
